bg_tile_renderer: RTL and testbench



---
 rtl/bg_tile_pkg.sv | 37 +++
 rtl/tile_rom_addr_map.sv | 41 ++++
 rtl/bg_tile_renderer.sv | 112 +++++++++++
 tb/tb_bg_tile_renderer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bg_tile_pkg.sv
// Shared constants and tile-word layout for the background tile renderer.
package bg_tile_pkg;

  localparam int TILE_W = 16;
  localparam int TILE_H = 16;
  localparam int UV_W   = $clog2(TILE_W);

  localparam int TILE_WORD_BITS = 9;
  localparam int PROPS_MSB = 8;
  localparam int PROPS_LSB = 6;
  localparam int SROW_MSB  = 5;
  localparam int SROW_LSB  = 3;
  localparam int SCOL_MSB  = 2;
  localparam int SCOL_LSB  = 0;

  localparam int PROP_VISIBLE = 2;
  localparam int PROP_VFLIP   = 1;
  localparam int PROP_HFLIP   = 0;

  localparam logic [11:0] DEF_KEY_COLOR = 12'hF0F;
  localparam logic [11:0] DEF_BG_COLOR  = 12'h6BF;

  typedef struct packed {
    logic [2:0] props;
    logic [2:0] sheet_row;
    logic [2:0] sheet_col;
  } tile_word_t;

  function automatic tile_word_t decode_tile(input logic [TILE_WORD_BITS-1:0] w);
    tile_word_t t;
    t.props     = w[PROPS_MSB:PROPS_LSB];
    t.sheet_row = w[SROW_MSB:SROW_LSB];
    t.sheet_col = w[SCOL_MSB:SCOL_LSB];
    return t;
  endfunction

endpackage

// File: rtl/tile_rom_addr_map.sv
// S1 of the renderer: applies tile flips to the in-tile texel position and
// registers the tile-sheet ROM address together with the tile's visible bit.
module tile_rom_addr_map
  import bg_tile_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [TILE_WORD_BITS-1:0] tile_word_i,
  input  logic [UV_W-1:0]           u_i,
  input  logic [UV_W-1:0]           v_i,
  output logic [13:0]               rom_addr_o,
  output logic                      visible_o
);

  tile_word_t      tw;
  logic [UV_W-1:0] u_flip, v_flip;
  logic [13:0]     rom_addr_d, rom_addr_q;
  logic            visible_q;

  // Inverting a 4-bit coordinate is the same as 15 - coord.
  always_comb begin
    tw         = decode_tile(tile_word_i);
    u_flip     = tw.props[PROP_HFLIP] ? ~u_i : u_i;
    v_flip     = tw.props[PROP_VFLIP] ? ~v_i : v_i;
    rom_addr_d = {tw.sheet_row, v_flip, tw.sheet_col, u_flip};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      visible_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      visible_q  <= tw.props[PROP_VISIBLE];
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign visible_o  = visible_q;

endmodule

// File: rtl/bg_tile_renderer.sv
// Three-stage background tile pixel pipeline: scroll + map lookup, texel fetch, colour select.
// Optional BG_TILE_GRID_EN draws a white grid on tile row/column 0 of visible pixels.
module bg_tile_renderer
  import bg_tile_pkg::*;
#(
  parameter int          TILE_COLS = 40,
  parameter int          TILE_ROWS = 30,
  parameter logic [11:0] BG_COLOR  = DEF_BG_COLOR,
  parameter logic [11:0] KEY_COLOR = DEF_KEY_COLOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [3:0]  bg_x_offset,
  output logic [15:0] bg_rd_addr,
  input  logic [31:0] bg_rd_data,
  output logic [13:0] tile_rom_addr,
  input  logic [11:0] tile_rom_data,
  output logic [11:0] rgb,
  output logic        bg_opaque
);

  logic [10:0]     px;
  logic [6:0]      col_raw, col;
  logic [15:0]     bg_rd_addr_d, bg_rd_addr_q;
  logic [UV_W-1:0] u0_q, v0_q;
  logic [1:0]      vld_pipe;
  logic            visible1;
  logic [11:0]     rgb_d, rgb_q;
  logic            opaque_d, opaque_q;

  // Rows never wrap, so the row count only documents the map size.
  logic unused_ok;
  assign unused_ok = ^{bg_rd_data[31:TILE_WORD_BITS], 16'(TILE_ROWS)};

  // S0: scrolled column with a single wrap back into the map.
  always_comb begin
    px           = {1'b0, x} + {7'd0, bg_x_offset};
    col_raw      = px[10:4];
    col          = (col_raw >= 7'(TILE_COLS)) ? col_raw - 7'(TILE_COLS) : col_raw;
    bg_rd_addr_d = video_on ? 16'(y[9:4]) * 16'(TILE_COLS) + 16'(col) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_rd_addr_q <= '0;
      u0_q         <= '0;
      v0_q         <= '0;
      vld_pipe     <= '0;
    end else begin
      bg_rd_addr_q <= bg_rd_addr_d;
      u0_q         <= px[UV_W-1:0];
      v0_q         <= y[UV_W-1:0];
      vld_pipe     <= {vld_pipe[0], video_on};
    end
  end

  tile_rom_addr_map u_map (
    .clk         (clk),
    .reset_n     (reset_n),
    .tile_word_i (bg_rd_data[TILE_WORD_BITS-1:0]),
    .u_i         (u0_q),
    .v_i         (v0_q),
    .rom_addr_o  (tile_rom_addr),
    .visible_o   (visible1)
  );

`ifdef BG_TILE_GRID_EN
  logic grid1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) grid1_q <= 1'b0;
    else          grid1_q <= (u0_q == '0) || (v0_q == '0);
  end
`endif

  // S2: colour select on the arriving texel.
  always_comb begin
    rgb_d    = '0;
    opaque_d = 1'b0;
    if (vld_pipe[1]) begin
`ifdef BG_TILE_GRID_EN
      if (grid1_q) begin
        rgb_d    = 12'hFFF;
        opaque_d = 1'b1;
      end else
`endif
      if (!visible1 || tile_rom_data == KEY_COLOR) begin
        rgb_d = BG_COLOR;
      end else begin
        rgb_d    = tile_rom_data;
        opaque_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q    <= '0;
      opaque_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      opaque_q <= opaque_d;
    end
  end

  assign bg_rd_addr = bg_rd_addr_q;
  assign rgb        = rgb_q;
  assign bg_opaque  = opaque_q;

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Scoreboard bench for bg_tile_renderer with behavioural RAM/ROM and reference model.
module tb_bg_tile_renderer;

  localparam logic [11:0] KEY = 12'hF0F;
  localparam logic [11:0] BGC = 12'h6BF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [3:0]  bg_x_offset = '0;
  logic [15:0] bg_rd_addr;
  logic [31:0] bg_rd_data;
  logic [13:0] tile_rom_addr;
  logic [11:0] tile_rom_data;
  logic [11:0] rgb;
  logic        bg_opaque;

  logic [31:0] ram [0:65535];
  logic [11:0] rom [0:16383];

  assign bg_rd_data    = ram[bg_rd_addr];
  assign tile_rom_data = rom[tile_rom_addr];

  bg_tile_renderer #(
    .TILE_COLS (40),
    .TILE_ROWS (30),
    .BG_COLOR  (BGC),
    .KEY_COLOR (KEY)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .video_on      (video_on),
    .x             (x),
    .y             (y),
    .bg_x_offset   (bg_x_offset),
    .bg_rd_addr    (bg_rd_addr),
    .bg_rd_data    (bg_rd_data),
    .tile_rom_addr (tile_rom_addr),
    .tile_rom_data (tile_rom_data),
    .rgb           (rgb),
    .bg_opaque     (bg_opaque)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t q_ra[$], q_ta[$], q_px[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  function automatic exp_t mk(input int due, input logic [15:0] val);
    exp_t e;
    e.due = due;
    e.val = val;
    return e;
  endfunction

  // Reference model: pixel sampled at posedge c.
  task automatic push_pixel(input int c, input bit von, input int xx, input int yy,
                            input int off, input bit with_ra);
    int px, u, v, uu, vv, addr, ta;
    logic [31:0] w;
    logic [11:0] tex, o_rgb;
    bit o_op;
    px   = xx + off;
    u    = px % 16;
    v    = yy % 16;
    addr = von ? (yy / 16) * 40 + (px / 16) % 40 : 0;
    w    = ram[addr];
    uu   = w[6] ? 15 - u : u;
    vv   = w[7] ? 15 - v : v;
    ta   = int'(w[5:3]) * 2048 + vv * 128 + int'(w[2:0]) * 16 + uu;
    tex  = rom[ta];
    if (!von) begin
      o_rgb = 12'h000; o_op = 1'b0;
`ifdef BG_TILE_GRID_EN
    end else if (u == 0 || v == 0) begin
      o_rgb = 12'hFFF; o_op = 1'b1;
`endif
    end else if (!w[8] || tex == KEY) begin
      o_rgb = BGC; o_op = 1'b0;
    end else begin
      o_rgb = tex; o_op = 1'b1;
    end
    if (with_ra) q_ra.push_back(mk(c, 16'(addr)));
    q_ta.push_back(mk(c + 1, 16'(ta)));
    q_px.push_back(mk(c + 2, {3'b000, o_op, o_rgb}));
  endtask

  task automatic drive(input bit von, input int xx, input int yy, input int off);
    video_on    = von;
    x           = 10'(xx);
    y           = 10'(yy);
    bg_x_offset = 4'(off);
    push_pixel(cyc + 1, von, xx, yy, off, 1'b1);
    @(negedge clk);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (q_ra.size() > 0 && q_ra[0].due <= cyc) begin
      e = q_ra.pop_front();
      chk("bg_rd_addr", bg_rd_addr, e.val);
    end
    while (q_ta.size() > 0 && q_ta[0].due <= cyc) begin
      e = q_ta.pop_front();
      chk("tile_rom_addr", {2'b00, tile_rom_addr}, e.val);
    end
    while (q_px.size() > 0 && q_px[0].due <= cyc) begin
      e = q_px.pop_front();
      chk("opaque_rgb", {3'b000, bg_opaque, rgb}, e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, yl, off;
    int dx [7] = '{100, 636, 19, 200, 300, 700, 1023};
    int dy [7] = '{64, 32, 52, 200, 100, 100, 500};
    int doff [7] = '{5, 15, 0, 0, 2, 0, 15};
    bit dvon [7] = '{1, 1, 1, 1, 1, 0, 1};

    for (int i = 0; i < 65536; i++) ram[i] = $urandom;
    for (int i = 0; i < 16384; i++) rom[i] = ($urandom_range(7) == 0) ? KEY : 12'($urandom);
    ram[166]   = 32'hABCDE109;  // visible, sheet 1/1
    ram[121]   = 32'h5A5A5FEA;  // all props set, sheet row 5, col 2
    ram[492]   = 32'h00000100;  // visible, sheet 0/0 -> key texel
    ram[258]   = 32'h0000001C;  // hidden tile
    rom[11692] = 12'h0A0;
    rom[1032]  = KEY;

    // Reset held with active video: everything stays zero.
    repeat (3) begin
      @(negedge clk);
      video_on = 1'b1;
      x = 10'($urandom);
      y = 10'($urandom);
      bg_x_offset = 4'($urandom);
    end
    @(posedge clk); #1;
    chk("reset_rgb", {4'h0, rgb}, 16'h0);
    chk("reset_opaque", {15'h0, bg_opaque}, 16'h0);
    chk("reset_bg_rd_addr", bg_rd_addr, 16'h0);
    chk("reset_tile_rom_addr", {2'b00, tile_rom_addr}, 16'h0);

    @(negedge clk);
    reset_n = 1'b1;
    r = cyc + 1;
    // Cleared stages behave like blanked pixels at coordinate 0.
    q_px.push_back(mk(r, 16'h0));
    push_pixel(r - 1, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 7; i++) drive(dvon[i], dx[i], dy[i], doff[i]);

    yl  = $urandom_range(479);
    off = $urandom_range(15);
    for (int i = 0; i < 640; i++) drive(1'b1, i, yl, off);

    yl = $urandom_range(479);
    for (int i = 0; i < 800; i++) drive(i < 640, i, yl, $urandom_range(15));

    for (int i = 0; i < 200; i++)
      drive($urandom_range(3) != 0, $urandom_range(1023), $urandom_range(1023), $urandom_range(15));

    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0);
    for (int k = 0; k < 10 && (q_ra.size() + q_ta.size() + q_px.size()) > 0; k++) @(negedge clk);
    chk("drain_pending", 16'(q_ra.size() + q_ta.size() + q_px.size()), 16'h0);

    // Asynchronous reset mid-line clears the pipe without a clock edge.
    video_on = 1'b1; x = 10'd100; y = 10'd64; bg_x_offset = 4'd5;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_rgb", {4'h0, rgb}, 16'h0);
    chk("midreset_opaque", {15'h0, bg_opaque}, 16'h0);
    chk("midreset_bg_rd_addr", bg_rd_addr, 16'h0);
    chk("midreset_tile_rom_addr", {2'b00, tile_rom_addr}, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
